// File: rtl/rx_pkg.sv
// Shared definitions for the receive-path word aligner.
//   align_state_t : lock-qualification states
//   COMMA_P/N     : 7-bit comma prefixes (both running disparities)
//   K28_5_*/D21_5 : code groups that are handy for alignment streams
//   isComma       : true when a 10-bit word starts with a comma prefix
//   windowSlice   : 10-bit candidate at bit offset k of a 20-bit window
//   satInc        : 4-bit increment that sticks at 15
package rx_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    CONFIRM,
    LOCKED
  } align_state_t;

  localparam logic [6:0] COMMA_P   = 7'b0011111;
  localparam logic [6:0] COMMA_N   = 7'b1100000;

  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;
  localparam logic [9:0] D21_5     = 10'h2AA;

  function automatic logic isComma(input logic [9:0] word);
    return (word[9:3] == COMMA_P) || (word[9:3] == COMMA_N);
  endfunction

  // Offset k picks window[19-k -: 10]; bit 19 is the oldest received bit.
  function automatic logic [9:0] windowSlice(input logic [19:0] window,
                                             input logic [3:0]  k);
    return 10'(window >> (5'd10 - {1'b0, k}));
  endfunction

  function automatic logic [3:0] satInc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/comma_aligner_if.sv
// Word-level bus between deserializer, aligner and 8b/10b decoder.
//   RxUnaligned_10 : raw deserializer word, bit 9 oldest
//   RxAlignEn      : 1 = realignment allowed
//   RxParallel_10  : aligned code group
//   RxAligned      : lock indicator
//   CommaDetect    : emitted word is a comma code group
//   AlignOffset    : current bit offset, 0..9
// master = the side driving raw words (deserializer/control),
// slave  = the aligner itself.
interface comma_aligner_if;
  logic [9:0] RxUnaligned_10;
  logic       RxAlignEn;
  logic [9:0] RxParallel_10;
  logic       RxAligned;
  logic       CommaDetect;
  logic [3:0] AlignOffset;

  modport master (
    output RxUnaligned_10, RxAlignEn,
    input  RxParallel_10, RxAligned, CommaDetect, AlignOffset
  );

  modport slave (
    input  RxUnaligned_10, RxAlignEn,
    output RxParallel_10, RxAligned, CommaDetect, AlignOffset
  );
endinterface

// File: rtl/comma_aligner_detect.sv
// Combinational comma search over a 20-bit sliding window.
//   window : {previous word, current word}, bit 19 oldest
//   hit    : some offset 0..9 carries a comma prefix
//   hitK   : lowest offset that matched (0 when no hit)
module comma_detect
  import rx_pkg::*;
(
  input  logic [19:0] window,
  output logic        hit,
  output logic [3:0]  hitK
);

  // NOTE: every output gets a default before the search loop so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    hit  = 1'b0;
    hitK = 4'd0;
    // Scan high to low so the last assignment, the lowest offset, wins.
    for (int k = 9; k >= 0; k--) begin
      if (isComma(windowSlice(window, 4'(k)))) begin
        hit  = 1'b1;
        hitK = 4'(k);
      end
    end
  end

endmodule

// File: rtl/comma_aligner.sv
// Receive-path word aligner: finds the comma in the deserializer stream,
// qualifies lock over repeated commas at one offset and emits aligned
// code groups to the 8b/10b decoder.
//   BitCLK_10 : word clock, rising edge
//   Reset     : synchronous, active-high
//   rx        : comma_aligner_if.slave (raw words in, aligned words out)
// CONFIRM_COUNT commas at one offset declare lock; LOSS_COUNT consecutive
// commas at another offset drop it. Both must be 1..15.
module comma_aligner
  import rx_pkg::*;
#(
  parameter int CONFIRM_COUNT = 3,
  parameter int LOSS_COUNT    = 4
) (
  input logic            BitCLK_10,
  input logic            Reset,
  comma_aligner_if.slave rx
);

  localparam logic [3:0] ConfirmTarget = 4'(CONFIRM_COUNT);
  localparam logic [3:0] LossTarget    = 4'(LOSS_COUNT);

  align_state_t stateQ, stateD;
  logic [9:0]   prevQ;
  logic [3:0]   offsetQ, offsetD;
  logic [3:0]   confirmCntQ, confirmCntD;
  logic [3:0]   lossCntQ, lossCntD;
  logic [9:0]   parallelQ;
  logic         alignedQ;
  logic         commaQ;

  logic [19:0]  window;
  logic         hit;
  logic [3:0]   hitK;
  logic [9:0]   nextWord;

  assign window = {prevQ, rx.RxUnaligned_10};

  comma_detect uDetect (
    .window (window),
    .hit    (hit),
    .hitK   (hitK)
  );

  // Next-state logic. With RxAlignEn low, hits are ignored entirely and
  // everything holds.
  always_comb begin
    stateD      = stateQ;
    offsetD     = offsetQ;
    confirmCntD = confirmCntQ;
    lossCntD    = lossCntQ;

    if (rx.RxAlignEn && hit) begin
      case (stateQ)
        SEARCH: begin
          offsetD     = hitK;
          confirmCntD = 4'd1;
          lossCntD    = 4'd0;
          stateD      = (ConfirmTarget <= 4'd1) ? LOCKED : CONFIRM;
        end

        CONFIRM: begin
          if (hitK == offsetQ) begin
            confirmCntD = satInc(confirmCntQ);
            if (satInc(confirmCntQ) >= ConfirmTarget) begin
              stateD   = LOCKED;
              lossCntD = 4'd0;
            end
          end else begin
            // A comma elsewhere restarts qualification at the new offset.
            offsetD     = hitK;
            confirmCntD = 4'd1;
          end
        end

        LOCKED: begin
          if (hitK == offsetQ) begin
            lossCntD = 4'd0;
          end else begin
            lossCntD = satInc(lossCntQ);
            if (satInc(lossCntQ) >= LossTarget) begin
              // offsetQ is kept: output stays put until the next hit.
              stateD   = SEARCH;
              lossCntD = 4'd0;
            end
          end
        end

        default: stateD = SEARCH;
      endcase
    end
  end

  // The emitted word already uses the offset adopted this cycle.
  assign nextWord = windowSlice(window, offsetD);

  // NOTE: state and output registers use non-blocking assignments so every
  // register samples the pre-edge values and ordering inside the block
  // cannot change behaviour.
  always_ff @(posedge BitCLK_10) begin
    if (Reset) begin
      stateQ      <= SEARCH;
      prevQ       <= '0;
      offsetQ     <= '0;
      confirmCntQ <= '0;
      lossCntQ    <= '0;
      parallelQ   <= '0;
      alignedQ    <= 1'b0;
      commaQ      <= 1'b0;
    end else begin
      stateQ      <= stateD;
      prevQ       <= rx.RxUnaligned_10;
      offsetQ     <= offsetD;
      confirmCntQ <= confirmCntD;
      lossCntQ    <= lossCntD;
      parallelQ   <= nextWord;
      alignedQ    <= (stateD == LOCKED);
      commaQ      <= isComma(nextWord);
    end
  end

  assign rx.RxParallel_10 = parallelQ;
  assign rx.RxAligned     = alignedQ;
  assign rx.CommaDetect   = commaQ;
  assign rx.AlignOffset   = offsetQ;

endmodule

// File: tb/tb_comma_aligner.sv
// Self-checking bench for comma_aligner. A bit-level stream of code groups
// is cut into 10-bit words; inserting extra bits shifts the alignment.
// A bit-list reference model predicts each edge's outputs into a queue and
// a negedge monitor compares the DUT against it.
module tb_comma_aligner;
  import rx_pkg::*;

  localparam int CONF = 3;
  localparam int LOSS = 4;

  logic BitCLK_10 = 1'b0;
  logic Reset     = 1'b1;

  always #5 BitCLK_10 = ~BitCLK_10;

  comma_aligner_if bus ();

  comma_aligner #(
    .CONFIRM_COUNT (CONF),
    .LOSS_COUNT    (LOSS)
  ) dut (
    .BitCLK_10 (BitCLK_10),
    .Reset     (Reset),
    .rx        (bus)
  );

  typedef struct {
    logic [9:0] word;
    logic       aligned;
    logic       comma;
    logic [3:0] off;
  } exp_t;

  typedef bit bitwin_t [20];

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cycleNo    = 0;

  // ---------------- reference model (bit-list view) ----------------
  logic [9:0] mPrev;
  bit         mLocked;
  bit         mHunting;
  int         mOffset;
  int         mSeen;
  int         mStrays;

  // Comma = two equal bits followed by five copies of their complement.
  function automatic bit startsComma(input bitwin_t b, input int k);
    if (b[k] != b[k+1]) return 1'b0;
    for (int i = 2; i < 7; i++)
      if (b[k+i] == b[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void modelStep(input logic [9:0] w, input bit en,
                                    input bit rst);
    exp_t    e;
    bitwin_t b;
    int      hitAt;
    if (rst) begin
      mPrev = '0; mLocked = 0; mHunting = 1; mOffset = 0;
      mSeen = 0;  mStrays = 0;
      e.word = '0; e.aligned = 0; e.comma = 0; e.off = '0;
      expQ.push_back(e);
      return;
    end
    // b[0] is the oldest received bit of the two words.
    for (int i = 0; i < 10; i++) begin
      b[i]      = mPrev[9-i];
      b[10 + i] = w[9-i];
    end
    hitAt = -1;
    for (int k = 9; k >= 0; k--)
      if (startsComma(b, k)) hitAt = k;

    if (en && hitAt >= 0) begin
      if (mLocked) begin
        if (hitAt == mOffset) mStrays = 0;
        else begin
          mStrays++;
          if (mStrays >= LOSS) begin
            mLocked = 0; mHunting = 1; mStrays = 0;
          end
        end
      end else begin
        if (mHunting || hitAt != mOffset) begin
          mOffset = hitAt; mSeen = 1; mHunting = 0;
        end else begin
          mSeen++;
        end
        if (mSeen >= CONF) begin
          mLocked = 1; mStrays = 0;
        end
      end
    end

    for (int i = 0; i < 10; i++) e.word[9-i] = b[mOffset + i];
    e.comma   = startsComma(b, mOffset);
    e.aligned = mLocked;
    e.off     = 4'(mOffset);
    expQ.push_back(e);
    mPrev = w;
  endfunction

  // ---------------- stream generation ----------------
  bit bitQ[$];
  int patIdx = 0;

  function automatic void pushGroup(input logic [9:0] g);
    for (int i = 9; i >= 0; i--) bitQ.push_back(g[i]);
  endfunction

  function automatic void pushJunk(input int n);
    for (int i = 0; i < n; i++) bitQ.push_back(1'($urandom_range(1, 0)));
  endfunction

  function automatic void restartStream();
    bitQ.delete();
    patIdx = 0;
  endfunction

  function automatic logic [9:0] nextWord(input bit randomMode);
    logic [9:0] w;
    while (bitQ.size() < 10) begin
      if (randomMode) begin
        case ($urandom_range(3, 0))
          0:       pushGroup(K28_5_RDN);
          1:       pushGroup(K28_5_RDP);
          2:       pushGroup(D21_5);
          default: pushGroup(10'($urandom));
        endcase
      end else begin
        case (patIdx)
          0:       pushGroup(K28_5_RDN);
          1:       pushGroup(D21_5);
          default: pushGroup(K28_5_RDP);
        endcase
        patIdx = (patIdx + 1) % 3;
      end
    end
    for (int i = 9; i >= 0; i--) w[i] = bitQ.pop_front();
    return w;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic [9:0] w, input bit en, input bit rst);
    bus.RxUnaligned_10 = w;
    bus.RxAlignEn      = en;
    Reset              = rst;
    @(posedge BitCLK_10);
    modelStep(w, en, rst);
    cycleNo++;
    #1;
  endtask

  task automatic runStream(input int n, input bit en);
    for (int i = 0; i < n; i++) cycle(nextWord(1'b0), en, 1'b0);
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) cycle(10'd0, 1'b1, 1'b1);
    restartStream();
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [9:0] act,
                       input logic [9:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %h, expected %h",
               name, cycleNo, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge BitCLK_10);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("RxParallel_10", bus.RxParallel_10, e.word);
        check("RxAligned", 10'(bus.RxAligned), 10'(e.aligned));
        check("CommaDetect", 10'(bus.CommaDetect), 10'(e.comma));
        check("AlignOffset", 10'(bus.AlignOffset), 10'(e.off));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    bus.RxUnaligned_10 = '0;
    bus.RxAlignEn      = 1'b1;

    // Already aligned at offset 0.
    doReset(2);
    runStream(12, 1'b1);

    // Reset mid-lock, then the stream shifted by 3 bits.
    doReset(1);
    pushJunk(3);
    runStream(12, 1'b1);

    // Loss of lock: move to offset 7, drop after 4 stray commas, relock.
    pushJunk(4);
    runStream(16, 1'b1);

    // RxAlignEn low: lock at 0, shift to 4, offset must stay frozen.
    doReset(1);
    runStream(8, 1'b1);
    pushJunk(4);
    runStream(16, 1'b0);
    runStream(12, 1'b1);

    // Confirm restart: first comma at offset 2, later ones at offset 5.
    doReset(1);
    pushJunk(2);
    runStream(3, 1'b1);
    pushJunk(3);
    runStream(10, 1'b1);

    // Randomized: mixed groups, slips, enable toggles, rare resets.
    doReset(1);
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      bit en;
      if ($urandom_range(39, 0) == 0) pushJunk($urandom_range(9, 1));
      rst = ($urandom_range(199, 0) == 0);
      en  = ($urandom_range(9, 0) != 0);
      cycle(nextWord(1'b1), en, rst);
    end

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 5 && expQ.size() != 0; i++) @(negedge BitCLK_10);
    @(negedge BitCLK_10);
    check("scoreboard_drain", 10'(expQ.size()), 10'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
